screen_writer: RTL and testbench

SCREEN_WRITER -- requirements
Module: screen_writer

---
 rtl/screen_writer.sv | 156 +++++++++++++++
 tb/tb_screen_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/screen_writer.sv
// screen_writer: character-cell text writer for a 40x30 screen memory.
//
// Writes screen codes at a self-advancing cursor, supports direct cursor
// loads, and fills the whole screen with FILL_CODE on a clear request.
//
// Optional feature: define SCREEN_WRITER_NEWLINE_EN to treat code 8'h0A as
// a newline (cursor to column 0 of the next row, no memory write).
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   wr_valid, wr_code     character write request and its screen code
//   wr_ready              write accepted this cycle (IDLE, not in reset)
//   clr_req               clear-screen request
//   cur_set, cur_col/row  cursor load request and target position
//   mem_we/addr/data      registered screen-memory write port
//   cursor_col/row        current cursor position
//   busy                  clear in progress
module screen_writer #(
    parameter logic [7:0] FILL_CODE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [7:0]  wr_code,
    output logic        wr_ready,
    input  logic        clr_req,
    input  logic        cur_set,
    input  logic [5:0]  cur_col,
    input  logic [4:0]  cur_row,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [5:0]  LastCol  = 6'd39;
    localparam logic [4:0]  LastRow  = 5'd29;
    localparam logic [10:0] LastAddr = 11'd1199;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e      state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic        we_q, we_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    logic        wr_accept;
    logic        is_newline;
    logic [10:0] cur_addr;

    // row*40 + col as shifts and adds
    assign cur_addr = {1'b0, row_q, 5'b0} + {3'b0, row_q, 3'b0} + {5'b0, col_q};

    assign wr_accept = (state_q == StIdle) && !reset && wr_valid && !clr_req && !cur_set;

`ifdef SCREEN_WRITER_NEWLINE_EN
    assign is_newline = (wr_code == 8'h0A);
`else
    assign is_newline = 1'b0;
`endif

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (clr_req) state_d = StClear;
            // Stay in CLEAR while addresses 0..1199 are presented on the port
            StClear: if (we_q && addr_q == LastAddr) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and memory-port next values
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    we_d   = 1'b1;
                    addr_d = '0;
                    data_d = FILL_CODE;
                end else if (cur_set) begin
                    if (cur_col <= LastCol && cur_row <= LastRow) begin
                        col_d = cur_col;
                        row_d = cur_row;
                    end
                end else if (wr_accept) begin
                    if (is_newline) begin
                        col_d = '0;
                        row_d = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = cur_addr;
                        data_d = wr_code;
                        if (col_q == LastCol) begin
                            col_d = '0;
                            row_d = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end
                end
            end
            StClear: begin
                if (addr_q == LastAddr) begin
                    col_d = '0;
                    row_d = '0;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + 11'd1;
                    data_d = FILL_CODE;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        wr_ready   = (state_q == StIdle) && !reset;
        busy       = (state_q == StClear);
        mem_we     = we_q;
        mem_addr   = addr_q;
        mem_data   = data_q;
        cursor_col = col_q;
        cursor_row = row_q;
    end

endmodule

// File: tb/tb_screen_writer.sv
// Directed self-checking bench for screen_writer.
module tb_screen_writer;

    localparam logic [7:0] Fill = 8'h20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_code = 8'h00;
    logic        wr_ready;
    logic        clr_req = 1'b0;
    logic        cur_set = 1'b0;
    logic [5:0]  cur_col = 6'd0;
    logic [4:0]  cur_row = 5'd0;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    screen_writer #(.FILL_CODE(Fill)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_code    (wr_code),
        .wr_ready   (wr_ready),
        .clr_req    (clr_req),
        .cur_set    (cur_set),
        .cur_col    (cur_col),
        .cur_row    (cur_row),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cursor(input int c, input int r);
        cur_set = 1'b1;
        cur_col = 6'(c);
        cur_row = 5'(r);
        tick();
        cur_set = 1'b0;
    endtask

    task automatic write_code(input logic [7:0] code);
        wr_valid = 1'b1;
        wr_code  = code;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        int pulses, bad_addr, bad_data, bad_ready, bad_busy;

        // Reset state
        #12;
        check_eq("rst_wr_ready", wr_ready, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_data", mem_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cursor", {cursor_row, cursor_col}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_eq("idle_wr_ready", wr_ready, 1);

        // First write after reset
        write_code(8'h41);
        check_eq("w41_we", mem_we, 1);
        check_eq("w41_addr", mem_addr, 0);
        check_eq("w41_data", mem_data, 8'h41);
        check_eq("w41_col", cursor_col, 1);
        check_eq("w41_row", cursor_row, 0);
        tick();
        check_eq("w41_we_one_cycle", mem_we, 0);
        check_eq("hold_addr", mem_addr, 0);
        check_eq("hold_data", mem_data, 8'h41);

        // Last cell and wrap to origin
        set_cursor(39, 29);
        check_eq("set_col", cursor_col, 39);
        check_eq("set_row", cursor_row, 29);
        check_eq("set_no_we", mem_we, 0);
        write_code(8'h42);
        check_eq("w42_addr", mem_addr, 1199);
        check_eq("w42_data", mem_data, 8'h42);
        check_eq("w42_col", cursor_col, 0);
        check_eq("w42_row", cursor_row, 0);

        // End of row wraps to next row
        set_cursor(39, 4);
        write_code(8'h43);
        check_eq("w43_addr", mem_addr, 199);
        check_eq("w43_col", cursor_col, 0);
        check_eq("w43_row", cursor_row, 5);

        // Out-of-range cursor loads are ignored
        set_cursor(40, 2);
        check_eq("oor_col_c", cursor_col, 0);
        check_eq("oor_col_r", cursor_row, 5);
        set_cursor(3, 30);
        check_eq("oor_row_c", cursor_col, 0);
        check_eq("oor_row_r", cursor_row, 5);

        // Newline code
        set_cursor(5, 3);
        write_code(8'h0A);
`ifdef SCREEN_WRITER_NEWLINE_EN
        check_eq("nl_we", mem_we, 0);
        check_eq("nl_col", cursor_col, 0);
        check_eq("nl_row", cursor_row, 4);
`else
        check_eq("nl_we", mem_we, 1);
        check_eq("nl_addr", mem_addr, 125);
        check_eq("nl_data", mem_data, 8'h0A);
        check_eq("nl_col", cursor_col, 6);
        check_eq("nl_row", cursor_row, 3);
`endif

        // Full clear; writes and cursor loads attempted mid-clear must be ignored
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        pulses = 0; bad_addr = 0; bad_data = 0; bad_ready = 0; bad_busy = 0;
        for (int i = 0; i < 1200; i++) begin
            if (mem_we) pulses++;
            if (mem_addr != 11'(i)) bad_addr++;
            if (mem_data != Fill) bad_data++;
            if (wr_ready) bad_ready++;
            if (!busy) bad_busy++;
            wr_valid = (i >= 100 && i < 110);
            wr_code  = 8'h55;
            cur_set  = (i >= 200 && i < 205);
            cur_col  = 6'd9;
            cur_row  = 5'd9;
            clr_req  = (i >= 300 && i < 303);
            tick();
        end
        wr_valid = 1'b0; cur_set = 1'b0; clr_req = 1'b0;
        check_eq("clr_pulses", pulses, 1200);
        check_eq("clr_bad_addr", bad_addr, 0);
        check_eq("clr_bad_data", bad_data, 0);
        check_eq("clr_bad_ready", bad_ready, 0);
        check_eq("clr_bad_busy", bad_busy, 0);
        check_eq("clr_end_we", mem_we, 0);
        check_eq("clr_end_busy", busy, 0);
        check_eq("clr_end_ready", wr_ready, 1);
        check_eq("clr_end_col", cursor_col, 0);
        check_eq("clr_end_row", cursor_row, 0);
        tick();
        check_eq("clr_no_restart", busy, 0);

        // Simultaneous clear, cursor load and write: clear wins
        set_cursor(7, 2);
        clr_req  = 1'b1;
        cur_set  = 1'b1;
        cur_col  = 6'd10;
        cur_row  = 5'd10;
        wr_valid = 1'b1;
        wr_code  = 8'h66;
        tick();
        clr_req = 1'b0; cur_set = 1'b0; wr_valid = 1'b0;
        check_eq("pri_busy", busy, 1);
        check_eq("pri_addr", mem_addr, 0);
        check_eq("pri_data", mem_data, Fill);
        check_eq("pri_col", cursor_col, 7);
        check_eq("pri_row", cursor_row, 2);

        // Reset in the middle of a clear
        repeat (500) tick();
        check_eq("mid_addr", mem_addr, 500);
        check_eq("mid_we", mem_we, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort_we", mem_we, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", wr_ready, 0);
        check_eq("abort_cursor", {cursor_row, cursor_col}, 0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_we || busy) pulses++;
        end
        check_eq("abort_no_writes", pulses, 0);
        check_eq("abort_addr", mem_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
